id_ex_stall_reg: RTL

ID_EX_STALL_REG -- requirements
Module: id_ex_stall_reg

---
 rtl/id_ex_stall_reg.sv | 79 +++++++
 1 files changed

// File: rtl/id_ex_stall_reg.sv
// id_ex_stall_reg: ID/EX pipeline register with load-use bubble insertion and stall-overrun detection.
// Optional stall cycle counter is enabled by defining STALL_PERF_CNT_EN.
module id_ex_stall_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_stall,
  input  logic [31:0] ID_pc,
  input  logic [31:0] ID_rs1_data,
  input  logic [31:0] ID_rs2_data,
  input  logic [31:0] ID_imm,
  input  logic [4:0]  ID_rd,
  input  logic [6:0]  ID_opcode,
  input  logic        ID_reg_write,
  input  logic        ID_mem_read,
  input  logic        ID_mem_write,
  input  logic        ID_mem_to_reg,
  input  logic        ID_alu_src,
  input  logic        ID_is_halted,
  output logic [31:0] EX_pc,
  output logic [31:0] EX_rs1_data,
  output logic [31:0] EX_rs2_data,
  output logic [31:0] EX_imm,
  output logic [4:0]  EX_rd,
  output logic [6:0]  EX_opcode,
  output logic        EX_reg_write,
  output logic        EX_mem_read,
  output logic        EX_mem_write,
  output logic        EX_mem_to_reg,
  output logic        EX_alu_src,
  output logic        EX_is_halted,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        stall_overrun,
  output logic [31:0] stall_cycles
);
  logic [1:0] run;
  assign pc_write    = !is_stall;
  assign if_id_write = !is_stall;
  // A bubble kills every side-effecting control bit; data fields pass through as don't-care.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      EX_pc         <= '0;
      EX_rs1_data   <= '0;
      EX_rs2_data   <= '0;
      EX_imm        <= '0;
      EX_rd         <= '0;
      EX_opcode     <= '0;
      EX_reg_write  <= 1'b0;
      EX_mem_read   <= 1'b0;
      EX_mem_write  <= 1'b0;
      EX_mem_to_reg <= 1'b0;
      EX_alu_src    <= 1'b0;
      EX_is_halted  <= 1'b0;
      run           <= '0;
      stall_overrun <= 1'b0;
    end else begin
      EX_pc         <= ID_pc;
      EX_rs1_data   <= ID_rs1_data;
      EX_rs2_data   <= ID_rs2_data;
      EX_imm        <= ID_imm;
      EX_mem_to_reg <= ID_mem_to_reg;
      EX_alu_src    <= ID_alu_src;
      EX_rd         <= is_stall ? 5'd0 : ID_rd;
      EX_opcode     <= is_stall ? 7'd0 : ID_opcode;
      EX_reg_write  <= ID_reg_write & !is_stall;
      EX_mem_read   <= ID_mem_read  & !is_stall;
      EX_mem_write  <= ID_mem_write & !is_stall;
      EX_is_halted  <= ID_is_halted & !is_stall;
      run           <= is_stall ? (run == 2'd3 ? run : run + 2'd1) : 2'd0;
      stall_overrun <= stall_overrun | (is_stall && run == 2'd2);
    end
`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_cycles <= '0;
    else if (is_stall) stall_cycles <= stall_cycles + 32'd1;
`else
  assign stall_cycles = '0;
`endif
endmodule
